vector_writeback_scheduler: RTL

Shares the single write port of the vector register file between the pipeline writeback stage and the memory load-return path, and optionally sweeps every vector register to zero after reset (the register file itself is not cleared by reset). Sits between writeback/load-return logic and the vector register file write port. Pipeline writebacks always win; load returns are buffered in a 2-entry FIFO. A starvation counter asks the pipeline for a bubble when a buffered load has waited too long.

---
 rtl/vector_writeback_scheduler_pkg.sv | 48 ++++
 rtl/vector_writeback_scheduler_if.sv | 40 ++++
 rtl/vector_writeback_fifo.sv | 59 +++++
 rtl/vector_writeback_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vector_writeback_scheduler_pkg.sv
// Shared types and widths for the vector writeback scheduler.
// Optional feature macro: VECTOR_CLEAR_ON_RESET_EN (post-reset register sweep).
// The width macros mirror the shared defines header; they are only defined
// here when the including build has not already provided them.

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 512
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif
`ifndef NUM_REGISTERS
`define NUM_REGISTERS 32
`endif

package vector_writeback_scheduler_pkg;

    localparam int unsigned RegIdxWidth  = `REG_IDX_WIDTH;
    localparam int unsigned VectorBits   = `VECTOR_BITS;
    localparam int unsigned VectorLanes  = `VECTOR_LANES;
    localparam int unsigned NumRegisters = `NUM_REGISTERS;
    localparam int unsigned SweepCntW    = $clog2(NumRegisters);
    localparam int unsigned StarveCntW   = 8;

    typedef logic [RegIdxWidth-1:0] reg_idx_t;
    typedef logic [VectorBits-1:0]  vec_t;
    typedef logic [VectorLanes-1:0] mask_t;

    // One register-file write: destination, lane mask and data.
    typedef struct packed {
        reg_idx_t idx;
        mask_t    mask;
        vec_t     value;
    } vwb_req_t;

    // Zero write to every lane, used by the post-reset sweep.
    function automatic vwb_req_t sweep_req(input reg_idx_t idx);
        vwb_req_t r;
        r.idx   = idx;
        r.mask  = '1;
        r.value = '0;
        return r;
    endfunction

endpackage

// File: rtl/vector_writeback_scheduler_if.sv
// Bundle of the pipeline, load-return and register-file port signals.
// master: the upstream/register-file side; slave: the scheduler itself.

interface vector_writeback_scheduler_if;
    import vector_writeback_scheduler_pkg::*;

    logic     wb_enable;
    reg_idx_t wb_reg;
    vec_t     wb_value;
    mask_t    wb_mask;

    logic     ld_valid;
    logic     ld_ready;
    reg_idx_t ld_reg;
    vec_t     ld_value;
    mask_t    ld_mask;
    logic     ld_starved;

    logic     init_done;

    logic     rf_enable;
    reg_idx_t rf_reg;
    vec_t     rf_value;
    mask_t    rf_mask;

    modport master (
        output wb_enable, wb_reg, wb_value, wb_mask,
        output ld_valid, ld_reg, ld_value, ld_mask,
        input  ld_ready, ld_starved, init_done,
        input  rf_enable, rf_reg, rf_value, rf_mask
    );

    modport slave (
        input  wb_enable, wb_reg, wb_value, wb_mask,
        input  ld_valid, ld_reg, ld_value, ld_mask,
        output ld_ready, ld_starved, init_done,
        output rf_enable, rf_reg, rf_value, rf_mask
    );

endinterface

// File: rtl/vector_writeback_fifo.sv
// Two-entry FIFO buffering load returns until the register-file port is free.
// Push into a full FIFO or pop from an empty one is ignored.

module vector_writeback_fifo
    import vector_writeback_scheduler_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  vwb_req_t push_data_i,
    input  logic     pop_i,
    output vwb_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    vwb_req_t   slot_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = slot_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy follows the push/pop pair; simultaneous push and pop keeps it.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= !wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= !rd_ptr_q;
        end
    end

    // Payload storage needs no reset; occupancy guards its validity.
    always_ff @(posedge clk) begin
        if (push_ok) slot_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vector_writeback_scheduler.sv
// Arbitrates the single vector register-file write port between the
// post-reset clear sweep, pipeline writebacks and buffered load returns.
// Optional feature macro: VECTOR_CLEAR_ON_RESET_EN (zero all registers after reset).

module vector_writeback_scheduler
    import vector_writeback_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                         clk,
    input logic                         reset,
    vector_writeback_scheduler_if.slave bus
);

    localparam logic [StarveCntW-1:0] StarveLimit = StarveCntW'(STARVE_LIMIT);

    vwb_req_t fifo_head;
    vwb_req_t ld_req;
    vwb_req_t wb_req;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     ld_ready;

    logic     sweep_active;
    reg_idx_t sweep_idx;
    logic     init_done;

    vwb_req_t              rf_q;
    vwb_req_t              rf_d;
    logic                  rf_enable_q;
    logic                  rf_enable_d;
    logic [StarveCntW-1:0] starve_q;
    logic [StarveCntW-1:0] starve_d;

`ifdef VECTOR_CLEAR_ON_RESET_EN
    logic                 sweep_active_q;
    logic [SweepCntW-1:0] sweep_idx_q;
    logic                 init_done_q;

    // Sweep counter walks 0..NumRegisters-1; init_done follows one cycle after
    // the last sweep write is driven on the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_active_q <= 1'b1;
            sweep_idx_q    <= '0;
            init_done_q    <= 1'b0;
        end else if (sweep_active_q) begin
            sweep_idx_q <= sweep_idx_q + 1'b1;
            if (sweep_idx_q == SweepCntW'(NumRegisters - 1)) sweep_active_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign sweep_active = sweep_active_q;
    assign sweep_idx    = RegIdxWidth'(sweep_idx_q);
    assign init_done    = init_done_q;

    // Upstream must hold off writebacks until init_done; such writes are dropped.
    wb_during_sweep_a : assert property (
        @(posedge clk) disable iff (reset) !(sweep_active_q && bus.wb_enable)
    );
`else
    assign sweep_active = 1'b0;
    assign sweep_idx    = '0;
    assign init_done    = 1'b1;
`endif

    // Depends only on registered state so upstream can use it without a loop.
    assign ld_ready  = !fifo_full && init_done;
    assign fifo_push = bus.ld_valid && ld_ready;

    assign ld_req.idx   = bus.ld_reg;
    assign ld_req.mask  = bus.ld_mask;
    assign ld_req.value = bus.ld_value;
    assign wb_req.idx   = bus.wb_reg;
    assign wb_req.mask  = bus.wb_mask;
    assign wb_req.value = bus.wb_value;

    vector_writeback_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (ld_req),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Port grant: sweep > pipeline > FIFO head. Idle cycles hold the last data.
    always_comb begin
        rf_d        = rf_q;
        rf_enable_d = 1'b0;
        fifo_pop    = 1'b0;
        if (sweep_active) begin
            rf_enable_d = 1'b1;
            rf_d        = sweep_req(sweep_idx);
        end else if (bus.wb_enable) begin
            rf_enable_d = 1'b1;
            rf_d        = wb_req;
        end else if (!fifo_empty) begin
            rf_enable_d = 1'b1;
            rf_d        = fifo_head;
            fifo_pop    = 1'b1;
        end
    end

    // Head wait time; saturates so ld_starved stays up until the head issues.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != StarveLimit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Registered register-file port and starvation count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_enable_q <= 1'b0;
            rf_q        <= '0;
            starve_q    <= '0;
        end else begin
            rf_enable_q <= rf_enable_d;
            rf_q        <= rf_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.ld_ready   = ld_ready;
    assign bus.ld_starved = (starve_q == StarveLimit);
    assign bus.init_done  = init_done;
    assign bus.rf_enable  = rf_enable_q;
    assign bus.rf_reg     = rf_q.idx;
    assign bus.rf_value   = rf_q.value;
    assign bus.rf_mask    = rf_q.mask;

endmodule
